// File: rtl/jzjpcc_operand_stage_if.sv
// Bundle of signals between decode/register-read and the operand stage.
//
// Handshake: valid_in qualifies every other input in the same cycle.
// While hazardStall_out is 1, the master holds all of its inputs unchanged.
// stall_in freezes the stage's output register. flush_in kills whatever is
// being presented. valid_out qualifies aluOperandA_out, aluOperandB_out and
// storeData_out.
//
// master: upstream/test side (drives the *_in signals)
// slave : the operand stage (drives the *_out signals)
interface jzjpcc_operand_stage_if #(
  parameter int XLEN     = 32,
  parameter int PC_MAX_B = 31,
  parameter int NUM_FWD  = 2
);
  logic                     valid_in;
  logic                     stall_in;
  logic                     flush_in;
  logic [2:0]               aluMuxMode_in;
  logic                     storeEn_in;
  logic [4:0]               rs1Addr_in;
  logic [4:0]               rs2Addr_in;
  logic [XLEN-1:0]          rs1Data_in;
  logic [XLEN-1:0]          rs2Data_in;
  logic [XLEN-1:0]          immediate_in;
  logic [PC_MAX_B:2]        currentPC_in;
  logic [NUM_FWD-1:0]       fwdValid_in;
  logic [5*NUM_FWD-1:0]     fwdAddr_in;
  logic [XLEN*NUM_FWD-1:0]  fwdData_in;
  logic [NUM_FWD-1:0]       fwdReady_in;
  logic                     hazardStall_out;
  logic [XLEN-1:0]          aluOperandA_out;
  logic [XLEN-1:0]          aluOperandB_out;
  logic [XLEN-1:0]          storeData_out;
  logic                     valid_out;

  modport master (
    output valid_in, stall_in, flush_in, aluMuxMode_in, storeEn_in,
           rs1Addr_in, rs2Addr_in, rs1Data_in, rs2Data_in, immediate_in,
           currentPC_in, fwdValid_in, fwdAddr_in, fwdData_in, fwdReady_in,
    input  hazardStall_out, aluOperandA_out, aluOperandB_out,
           storeData_out, valid_out
  );

  modport slave (
    input  valid_in, stall_in, flush_in, aluMuxMode_in, storeEn_in,
           rs1Addr_in, rs2Addr_in, rs1Data_in, rs2Data_in, immediate_in,
           currentPC_in, fwdValid_in, fwdAddr_in, fwdData_in, fwdReady_in,
    output hazardStall_out, aluOperandA_out, aluOperandB_out,
           storeData_out, valid_out
  );
endinterface

// File: rtl/jzjpcc_operand_stage.sv
// Execute-stage operand stage: forwarding resolution, load-use hazard
// detection and a registered ALU operand / store data output.
//
// Ports:
//   clock - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - jzjpcc_operand_stage_if.slave (decode inputs, forwarding
//           channels, hazardStall_out, registered operands and valid_out)
module jzjpcc_operand_stage #(
  parameter int XLEN     = 32,
  parameter int PC_MAX_B = 31,
  parameter int NUM_FWD  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  jzjpcc_operand_stage_if.slave   bus
);

  localparam logic [2:0] MODE_RS1_RS2 = 3'b000;
  localparam logic [2:0] MODE_RS1_IMM = 3'b001;
  localparam logic [2:0] MODE_PC_4    = 3'b010;
  localparam logic [2:0] MODE_PC_IMM  = 3'b011;
  localparam logic [2:0] MODE_LUI     = 3'b100;

  // Returns {pending, value}. Channels are scanned from index 0 and the first
  // hit is final, so a pending young producer cannot be bypassed by an older
  // ready one.
  function automatic logic [XLEN:0] resolve(
    input logic [4:0]              addr,
    input logic [XLEN-1:0]         rf_data,
    input logic [NUM_FWD-1:0]      f_valid,
    input logic [5*NUM_FWD-1:0]    f_addr,
    input logic [XLEN*NUM_FWD-1:0] f_data,
    input logic [NUM_FWD-1:0]      f_ready
  );
    logic          hit;
    logic [XLEN:0] r;
    hit = 1'b0;
    r   = {1'b0, rf_data};
    if (addr != 5'd0) begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!hit && f_valid[i] && (f_addr[5*i +: 5] == addr)) begin
          hit = 1'b1;
          r   = {~f_ready[i], f_data[XLEN*i +: XLEN]};
        end
      end
    end
    return r;
  endfunction

  logic [XLEN:0]   rs1_res;
  logic [XLEN:0]   rs2_res;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            rs1_pend;
  logic            rs2_pend;
  logic [XLEN-1:0] pc_op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            rs1_used;
  logic            rs2_used;
  logic            hazard;

  assign rs1_res  = resolve(bus.rs1Addr_in, bus.rs1Data_in, bus.fwdValid_in,
                            bus.fwdAddr_in, bus.fwdData_in, bus.fwdReady_in);
  assign rs2_res  = resolve(bus.rs2Addr_in, bus.rs2Data_in, bus.fwdValid_in,
                            bus.fwdAddr_in, bus.fwdData_in, bus.fwdReady_in);
  assign rs1_pend = rs1_res[XLEN];
  assign rs1_val  = rs1_res[XLEN-1:0];
  assign rs2_pend = rs2_res[XLEN];
  assign rs2_val  = rs2_res[XLEN-1:0];

  always_comb begin
    pc_op              = '0;
    pc_op[PC_MAX_B:0]  = {bus.currentPC_in, 2'b00};
  end

  always_comb begin
    op_a     = '0;
    op_b     = '0;
    rs1_used = 1'b0;
    rs2_used = bus.storeEn_in;
    case (bus.aluMuxMode_in)
      MODE_RS1_RS2: begin
        op_a     = rs1_val;
        op_b     = rs2_val;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      MODE_RS1_IMM: begin
        op_a     = rs1_val;
        op_b     = bus.immediate_in;
        rs1_used = 1'b1;
      end
      MODE_PC_4: begin
        op_a = pc_op;
        op_b = XLEN'(4);
      end
      MODE_PC_IMM: begin
        op_a = pc_op;
        op_b = bus.immediate_in;
      end
      MODE_LUI: begin
        op_b = bus.immediate_in;
      end
      default: begin
        // Reserved modes produce zero operands and still carry valid.
        op_a = '0;
        op_b = '0;
      end
    endcase
  end

  assign hazard = bus.valid_in & ~bus.flush_in &
                  ((rs1_used & rs1_pend) | (rs2_used & rs2_pend));
  assign bus.hazardStall_out = hazard;

  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] sd_q;
  logic            v_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      sd_q <= '0;
      v_q  <= 1'b0;
    end else if (bus.flush_in) begin
      v_q <= 1'b0;
    end else if (bus.stall_in) begin
      a_q  <= a_q;
      b_q  <= b_q;
      sd_q <= sd_q;
      v_q  <= v_q;
    end else if (hazard) begin
      v_q <= 1'b0;
    end else begin
      a_q  <= op_a;
      b_q  <= op_b;
      sd_q <= rs2_val;
      v_q  <= bus.valid_in;
    end
  end

  assign bus.aluOperandA_out = a_q;
  assign bus.aluOperandB_out = b_q;
  assign bus.storeData_out   = sd_q;
  assign bus.valid_out       = v_q;

endmodule

// File: tb/tb_jzjpcc_operand_stage.sv
module tb_jzjpcc_operand_stage;
  localparam int XLEN = 32;
  localparam int EW   = 2 + 3*XLEN;
  localparam logic [31:0] IMM = 32'hFFFF_FFF0;

  logic clock;
  logic reset;

  jzjpcc_operand_stage_if #(.XLEN(32), .PC_MAX_B(31), .NUM_FWD(2)) bus ();

  jzjpcc_operand_stage #(.XLEN(32), .PC_MAX_B(31), .NUM_FWD(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- vectors ----------------
  typedef struct {
    string       name;
    logic [2:0]  mode;
    logic        store;
    logic        vin;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [31:0] rs1d;
    logic [1:0]  fv;
    logic [9:0]  fa;
    logic [63:0] fd;
    logic [1:0]  fr;
    logic        ehaz;
    logic        ev;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] esd;
  } vec_t;

  vec_t vecs[$];

  // scoreboard entry: {check_data, valid, a, b, storeData}
  logic [EW-1:0] exp_q[$];
  int tests;
  int fails;

  function automatic vec_t mk(input string name, input logic [2:0] mode,
                              input logic store, input logic vin,
                              input logic [4:0] rs1a, input logic [4:0] rs2a,
                              input logic [31:0] rs1d, input logic [1:0] fv,
                              input logic [9:0] fa, input logic [63:0] fd,
                              input logic [1:0] fr, input logic ehaz,
                              input logic ev, input logic [31:0] ea,
                              input logic [31:0] eb, input logic [31:0] esd);
    vec_t v;
    v.name = name; v.mode = mode; v.store = store; v.vin = vin;
    v.rs1a = rs1a; v.rs2a = rs2a; v.rs1d = rs1d; v.fv = fv; v.fa = fa;
    v.fd = fd; v.fr = fr; v.ehaz = ehaz; v.ev = ev; v.ea = ea; v.eb = eb;
    v.esd = esd;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    bus.valid_in      = v.vin;
    bus.aluMuxMode_in = v.mode;
    bus.storeEn_in    = v.store;
    bus.rs1Addr_in    = v.rs1a;
    bus.rs2Addr_in    = v.rs2a;
    bus.rs1Data_in    = v.rs1d;
    bus.rs2Data_in    = 32'h20;
    bus.immediate_in  = IMM;
    bus.currentPC_in  = 30'h100;
    bus.fwdValid_in   = v.fv;
    bus.fwdAddr_in    = v.fa;
    bus.fwdData_in    = v.fd;
    bus.fwdReady_in   = v.fr;
  endtask

  task automatic check_haz(input string name, input logic exp);
    #1;
    tests++;
    if (bus.hazardStall_out !== exp) begin
      fails++;
      $display("FAIL %s hazardStall_out got %0b want %0b", name,
               bus.hazardStall_out, exp);
    end
  endtask

  task automatic expect_out(input logic chk, input logic v, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] sd);
    exp_q.push_back({chk, v, a, b, sd});
  endtask

  // ---------------- scoreboard ----------------
  task automatic edge_compare(input string name);
    logic [EW-1:0] e;
    @(posedge clock);
    #1;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      if (bus.valid_out !== e[3*XLEN] ||
          (e[3*XLEN+1] && ({bus.aluOperandA_out, bus.aluOperandB_out,
                            bus.storeData_out} !== e[3*XLEN-1:0]))) begin
        fails++;
        $display("FAIL %s got v=%0b a=%h b=%h sd=%h want v=%0b a=%h b=%h sd=%h%s",
                 name, bus.valid_out, bus.aluOperandA_out, bus.aluOperandB_out,
                 bus.storeData_out, e[3*XLEN], e[3*XLEN-1 -: 32],
                 e[2*XLEN-1 -: 32], e[XLEN-1:0],
                 e[3*XLEN+1] ? "" : " (data unchecked)");
      end
    end
  endtask

  task automatic apply_vec(input vec_t v);
    drive(v);
    check_haz({v.name, "_haz"}, v.ehaz);
    expect_out(v.ev, v.ev, v.ea, v.eb, v.esd);
    edge_compare(v.name);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t base;
    tests = 0;
    fails = 0;
    bus.stall_in = 1'b0;
    bus.flush_in = 1'b0;

    //               name        mode  st vin rs1 rs2 rs1d   fv     fa              fd                        fr     hz ev  A        B      SD
    vecs.push_back(mk("mode000", 3'd0, 0, 1, 1, 2, 32'h10, 2'b00, 10'd0,          64'd0,                    2'b00, 0, 1, 32'h10,  32'h20, 32'h20));
    vecs.push_back(mk("mode001", 3'd1, 0, 1, 1, 2, 32'h10, 2'b00, 10'd0,          64'd0,                    2'b00, 0, 1, 32'h10,  IMM,    32'h20));
    vecs.push_back(mk("mode010", 3'd2, 0, 1, 1, 2, 32'h10, 2'b00, 10'd0,          64'd0,                    2'b00, 0, 1, 32'h400, 32'h4,  32'h20));
    vecs.push_back(mk("mode011", 3'd3, 0, 1, 1, 2, 32'h10, 2'b00, 10'd0,          64'd0,                    2'b00, 0, 1, 32'h400, IMM,    32'h20));
    vecs.push_back(mk("mode100", 3'd4, 0, 1, 1, 2, 32'h10, 2'b00, 10'd0,          64'd0,                    2'b00, 0, 1, 32'h0,   IMM,    32'h20));
    vecs.push_back(mk("mode110", 3'd6, 0, 1, 1, 2, 32'h10, 2'b00, 10'd0,          64'd0,                    2'b00, 0, 1, 32'h0,   32'h0,  32'h20));
    vecs.push_back(mk("mode111", 3'd7, 0, 1, 1, 2, 32'h10, 2'b00, 10'd0,          64'd0,                    2'b00, 0, 1, 32'h0,   32'h0,  32'h20));
    vecs.push_back(mk("prio_ch0",3'd0, 0, 1, 5, 2, 32'h10, 2'b11, {5'd5, 5'd5},   {32'hBB, 32'hAA},         2'b11, 0, 1, 32'hAA,  32'h20, 32'h20));
    vecs.push_back(mk("prio_ch1",3'd0, 0, 1, 5, 2, 32'h10, 2'b10, {5'd5, 5'd5},   {32'hBB, 32'hAA},         2'b11, 0, 1, 32'hBB,  32'h20, 32'h20));
    vecs.push_back(mk("x0_guard",3'd0, 0, 1, 0, 2, 32'h0,  2'b01, {5'd0, 5'd0},   {32'h0, 32'hDEAD},        2'b01, 0, 1, 32'h0,   32'h20, 32'h20));
    vecs.push_back(mk("st_fwd",  3'd4, 1, 1, 1, 9, 32'h10, 2'b10, {5'd9, 5'd0},   {32'h99, 32'h0},          2'b10, 0, 1, 32'h0,   IMM,    32'h99));
    vecs.push_back(mk("ld_use",  3'd1, 0, 1, 7, 2, 32'h10, 2'b01, {5'd0, 5'd7},   {32'h0, 32'h0},           2'b00, 1, 0, 32'h0,   32'h0,  32'h0));
    vecs.push_back(mk("ld_ready",3'd1, 0, 1, 7, 2, 32'h10, 2'b01, {5'd0, 5'd7},   {32'h0, 32'h55},          2'b01, 0, 1, 32'h55,  IMM,    32'h20));
    vecs.push_back(mk("ld_pc4",  3'd2, 0, 1, 7, 2, 32'h10, 2'b01, {5'd0, 5'd7},   {32'h0, 32'h0},           2'b00, 0, 1, 32'h400, 32'h4,  32'h20));
    vecs.push_back(mk("rdy_ch0", 3'd0, 0, 1, 5, 2, 32'h10, 2'b11, {5'd5, 5'd5},   {32'hBB, 32'hAA},         2'b01, 0, 1, 32'hAA,  32'h20, 32'h20));
    vecs.push_back(mk("pend_ch0",3'd0, 0, 1, 5, 2, 32'h10, 2'b11, {5'd5, 5'd5},   {32'hBB, 32'hAA},         2'b10, 1, 0, 32'h0,   32'h0,  32'h0));
    vecs.push_back(mk("st_pend", 3'd3, 1, 1, 1, 7, 32'h10, 2'b01, {5'd0, 5'd7},   {32'h0, 32'h20},          2'b00, 1, 0, 32'h0,   32'h0,  32'h0));
    vecs.push_back(mk("rs2_unus",3'd3, 0, 1, 1, 7, 32'h10, 2'b01, {5'd0, 5'd7},   {32'h0, 32'h20},          2'b00, 0, 1, 32'h400, IMM,    32'h20));
    vecs.push_back(mk("rs2_m001",3'd1, 0, 1, 1, 7, 32'h10, 2'b01, {5'd0, 5'd7},   {32'h0, 32'h20},          2'b00, 0, 1, 32'h10,  IMM,    32'h20));
    vecs.push_back(mk("vin0",    3'd1, 0, 0, 7, 2, 32'h10, 2'b01, {5'd0, 5'd7},   {32'h0, 32'h0},           2'b00, 0, 0, 32'h0,   32'h0,  32'h0));

    base = vecs[0];

    // reset with nonzero inputs
    reset = 1'b1;
    drive(base);
    expect_out(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    edge_compare("reset");
    reset = 1'b0;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // stall holds outputs for three cycles while inputs change
    apply_vec(base);
    bus.stall_in = 1'b1;
    drive(vecs[2]);
    for (int c = 0; c < 3; c++) begin
      expect_out(1'b1, 1'b1, 32'h10, 32'h20, 32'h20);
      edge_compare("stall_hold");
    end

    // flush overrides stall
    bus.flush_in = 1'b1;
    expect_out(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    edge_compare("stall_flush");
    bus.stall_in = 1'b0;

    // flush with a pending operand: no hazard request, bubble out
    drive(vecs[11]);
    check_haz("flush_haz", 1'b0);
    expect_out(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    edge_compare("flush_pend");
    bus.flush_in = 1'b0;

    // stall with a pending operand holds the previous (invalid) output
    bus.stall_in = 1'b1;
    drive(vecs[11]);
    check_haz("stall_pend_haz", 1'b1);
    expect_out(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    edge_compare("stall_pend");
    bus.stall_in = 1'b0;

    // reset during a stall clears the held state
    apply_vec(vecs[3]);
    bus.stall_in = 1'b1;
    reset = 1'b1;
    expect_out(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    edge_compare("reset_mid_stall");
    reset = 1'b0;
    expect_out(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    edge_compare("post_reset_stall");
    bus.stall_in = 1'b0;

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL leftover scoreboard entries got %0d want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
